fib_seq_engine: RTL
===================

Name: fib_seq_engine

Overview:
Parametrised successor to the team's single-shot Fibonacci FSM. Computes the generalised additive recurrence T(k) = T(k-1) + T(k-2) mod 2^WIDTH from programmable seeds, with a configurable data width and term count. Two modes: single-result, or streaming every term T(0)..T(n). Adds a valid/ready output handshake, abort, and sticky overflow. Used as a sequence source for datapath test and scrambler-style blocks.

Parameters:
WIDTH, 32, width of seeds and terms
CNT_W, 16, width of term index n

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
n  in  CNT_W  index of the final term; captured on start
seed0  in  WIDTH  T(0); captured on start
seed1  in  WIDTH  T(1); captured on start
stream_mode  in  1  0 = single result, 1 = stream all terms; captured on start
abort  in  1  cancel the current job
out_ready  in  1  consumer ready
out_valid  out  1  out_data/out_index/out_last valid
out_data  out  WIDTH  term value; 0 when out_valid=0
out_index  out  CNT_W  k of the presented term; 0 when out_valid=0
out_last  out  1  presented term is T(n)
busy  out  1  state != IDLE
ovf  out  1  sticky: a carry occurred computing any T(2..n)
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- clk is the only clock. reset is asynchronous and active-high. Reset forces state IDLE and clears all registers. All outputs read 0 during and after reset.
- Registers: a=T(idx), b=T(idx+1), idx, n_q, mode_q, ovf.
- States: IDLE, RUN, EMIT.
- IDLE:
  - start=1 and abort=0 -> RUN.
  - Same edge: a=seed0, b=seed1, idx=0, capture n and mode, clear ovf.
  - start=1 with abort=1 is ignored.
- Advance step, the same in both modes: a<=b, b<=a+b (WIDTH bits, carry discarded), idx<=idx+1.
  - ovf<=1 if the carry is set and idx+2 <= n_q.
  - The carry from T(n+1) never sets ovf. Compare using CNT_W+1 bits so that n near max does not wrap.
- RUN, single mode (out_valid=0):
  - idx==n_q -> EMIT.
  - Otherwise advance.
  - out_valid first rises n+1 cycles after the start-capture edge.
- RUN, stream mode:
  - out_valid=1, out_data=a, out_index=idx, out_last=(idx==n_q).
  - Handshake on out_valid & out_ready.
  - On handshake with out_last=0: advance.
  - On handshake with out_last=1: -> IDLE and pulse done.
  - Without a handshake, all outputs hold stable.
  - The first beat is presented in the cycle after the start edge.
- EMIT (single mode only):
  - out_valid=1, out_data=a, out_index=n_q, out_last=1.
  - On handshake: -> IDLE and pulse done.
- done is registered and asserts the cycle after the final handshake, while state is already IDLE. A new start is accepted in that same cycle.
- abort in RUN or EMIT: -> IDLE at the next edge, out_valid drops, no done. abort has priority over a same-cycle handshake. ovf holds its value.
- start in RUN or EMIT is ignored.
- ovf holds its value in IDLE until the next accepted start.
- n=0 yields seed0. n=1 yields seed1.

Decomposition:
- fib_pkg holds:
  - the state enum typedef (IDLE/RUN/EMIT, 2-bit logic)
  - the mode enum typedef (SINGLE/STREAM)
- No sub-module. The adder and FSM are one always_ff/always_comb pair.

Test Plan:
1. WIDTH=16, seeds 0/1, n=10, single mode, out_ready=1:
   - out_valid rises 11 cycles after start with out_data=55, out_index=10, out_last=1.
   - done pulses next cycle; ovf=0.
2. Single mode, seeds 7/9:
   - n=0 -> out_data=7.
   - n=1 -> out_data=9.
   - Back-to-back start in the done cycle is accepted.
3. Stream mode, seeds 2/1, n=5, out_ready toggling 1,0,0,1:
   - Beats 2,1,3,4,7,11 with out_index 0..5, out_last only on 11.
   - Data stays stable during stalls.
   - done pulses once.
4. WIDTH=16, seeds 0/1, single mode:
   - n=24 -> 46368, ovf=0, even though T(25) wraps internally.
   - n=25 -> 9489, ovf=1.
   - ovf stays 1 in IDLE and clears on the next start.
5. Abort and ignored starts:
   - abort at idx=3 of an n=20 run -> IDLE next edge, no done.
   - start while busy is ignored.
   - start with abort in IDLE does not start a job.
6. reset asserted mid-stream with out_ready=0:
   - All outputs go to 0 immediately (asynchronously); busy=0.
   - A fresh start after release runs normally.

Source files
------------

// File: rtl/fib_seq_engine_pkg.sv
// Shared types for the Fibonacci-style sequence engine.
// Holds the controller state encoding and the captured output mode.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EMIT = 2'd2
    } state_e;

    typedef enum logic {
        SINGLE = 1'b0,
        STREAM = 1'b1
    } mode_e;

endpackage

// File: rtl/fib_seq_engine_if.sv
// Job request and result handshake bundle for fib_seq_engine.
// The master issues jobs and consumes terms; the slave is the engine.
interface fib_seq_engine_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] n;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic             stream_mode;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_index;
    logic             out_last;
    logic             busy;
    logic             ovf;
    logic             done;

    modport master (
        output start, n, seed0, seed1, stream_mode, abort, out_ready,
        input  out_valid, out_data, out_index, out_last, busy, ovf, done
    );

    modport slave (
        input  start, n, seed0, seed1, stream_mode, abort, out_ready,
        output out_valid, out_data, out_index, out_last, busy, ovf, done
    );
endinterface

// File: rtl/fib_seq_engine.sv
// Generalised additive recurrence T(k) = T(k-1) + T(k-2) mod 2^WIDTH from
// programmable seeds, with single-result or streaming output and sticky overflow.
//
// state | meaning
// IDLE  | waiting for start; done pulse and sticky ovf visible here
// RUN   | advancing terms; in stream mode also presenting T(idx)
// EMIT  | single mode only: presenting T(n) until accepted
module fib_seq_engine
    import fib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    fib_seq_engine_if.slave   bus
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum;
    logic [CNT_W:0]   idx_p2;
    logic             carry_counts;
    logic             at_last;
    logic             valid;
    logic             handshake;

    assign sum    = {1'b0, a_q} + {1'b0, b_q};
    assign idx_p2 = {1'b0, idx_q} + (CNT_W+1)'(2);
    // Only carries into terms up to T(n) count; T(n+1) is computed but never used.
    assign carry_counts = sum[WIDTH] && (idx_p2 <= {1'b0, n_q});
    assign at_last      = (idx_q == n_q);

    assign valid     = (state_q == EMIT) || ((state_q == RUN) && (mode_q == STREAM));
    assign handshake = valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = RUN;
                    a_d     = bus.seed0;
                    b_d     = bus.seed1;
                    idx_d   = '0;
                    n_d     = bus.n;
                    mode_d  = mode_e'(bus.stream_mode);
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if ((mode_q == SINGLE) && at_last) begin
                    state_d = EMIT;
                end else if ((mode_q == STREAM) && handshake && at_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if ((mode_q == SINGLE) || handshake) begin
                    a_d   = b_q;
                    b_d   = sum[WIDTH-1:0];
                    idx_d = idx_q + 1'b1;
                    ovf_d = ovf_q | carry_counts;
                end
            end
            EMIT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (handshake) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= SINGLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? a_q : '0;
    assign bus.out_index = valid ? ((state_q == EMIT) ? n_q : idx_q) : '0;
    assign bus.out_last  = valid && at_last;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ovf       = ovf_q;
    assign bus.done      = done_q;

endmodule
